// File: rtl/instruction_fetch_unit.sv
// Purpose : fetch stage; owns the PC, drives the text memory address and hands
//           {instruction, pc, fault} to decode through a 2-entry output buffer.
// Latency : 2 edges from a fetch issue to instruction_valid; 3 cycles after a redirect.
// Backpressure: instruction_ready=0 stops issue once buffer + in-flight read reach 2.
// Ports   : clock/reset; fetch_address -> memory, data_fetched <- memory (1-cycle);
//           redirect/redirect_target from branch resolution;
//           instruction/_pc/_fault/_valid with instruction_ready handshake to decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] TEXT_BEGIN = 32'h0040_0000,
  parameter logic [31:0] TEXT_END   = 32'h0040_FFFC
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] fetch_address,
  input  logic [31:0] data_fetched,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_fault,
  output logic        instruction_valid,
  input  logic        instruction_ready
);

  logic [31:0] r_req_pc;
  logic        r_inflight_valid;
  logic [31:0] r_inflight_pc;
  logic [1:0]  r_count;

  // Head entry drives the outputs directly; tail is the second buffer slot.
  logic [31:0] r_head_instr;
  logic [31:0] r_head_pc;
  logic        r_head_fault;
  logic [31:0] r_tail_instr;
  logic [31:0] r_tail_pc;
  logic        r_tail_fault;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_push_fault;
  logic [2:0]  w_occ;

  function automatic logic f_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_BEGIN) || (pc > TEXT_END);
  endfunction

  assign instruction_valid = (r_count != 2'd0);
  assign instruction       = r_head_instr;
  assign instruction_pc    = r_head_pc;
  assign instruction_fault = r_head_fault;
  assign fetch_address     = r_req_pc;

  assign w_pop        = instruction_valid & instruction_ready;
  assign w_push       = r_inflight_valid & ~redirect;
  assign w_push_fault = f_fault(r_inflight_pc);

  // Credit: the read issued now lands next cycle, so buffer + in-flight after
  // this cycle's pop must leave a free slot. pop is the only path into issue.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight_valid};
  assign w_issue = ~redirect & (w_occ < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req_pc         <= RESET_PC;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= 32'h0;
      r_count          <= 2'd0;
      r_head_instr     <= 32'h0;
      r_head_pc        <= 32'h0;
      r_head_fault     <= 1'b0;
      r_tail_instr     <= 32'h0;
      r_tail_pc        <= 32'h0;
      r_tail_fault     <= 1'b0;
    end else if (redirect) begin
      // Head registers keep their stale content; valid drops with count.
      r_req_pc         <= redirect_target;
      r_inflight_valid <= 1'b0;
      r_count          <= 2'd0;
    end else begin
      r_inflight_valid <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_req_pc;
        r_req_pc      <= r_req_pc + 32'd4;
      end

      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_instr <= data_fetched;
            r_head_pc    <= r_inflight_pc;
            r_head_fault <= w_push_fault;
            r_count      <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head_instr <= data_fetched;
            r_head_pc    <= r_inflight_pc;
            r_head_fault <= w_push_fault;
          end else if (w_push) begin
            r_tail_instr <= data_fetched;
            r_tail_pc    <= r_inflight_pc;
            r_tail_fault <= w_push_fault;
            r_count      <= 2'd2;
          end else if (w_pop) begin
            r_count      <= 2'd0;
          end
        end
        default: begin
          // Full: the credit rule means a push only arrives together with a pop.
          if (w_pop) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_head_fault <= r_tail_fault;
            if (w_push) begin
              r_tail_instr <= data_fetched;
              r_tail_pc    <= r_inflight_pc;
              r_tail_fault <= w_push_fault;
            end else begin
              r_count      <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Purpose : self-checking bench for instruction_fetch_unit with a scoreboard of expected PCs.
// Latency : checks startup (valid after 2 edges) and redirect (valid in N+3) timing.
// Backpressure: random instruction_ready; checks address freeze and gap-free delivery.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] TEXT_BEGIN = 32'h0040_0000;
  localparam logic [31:0] TEXT_END   = 32'h0040_FFFC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_address;
  logic [31:0] data_fetched;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_fault;
  logic        instruction_valid;
  logic        instruction_ready = 1'b0;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  instruction_fetch_unit #(
    .RESET_PC(RESET_PC), .TEXT_BEGIN(TEXT_BEGIN), .TEXT_END(TEXT_END)
  ) dut (
    .clock(clock), .reset(reset),
    .fetch_address(fetch_address), .data_fetched(data_fetched),
    .redirect(redirect), .redirect_target(redirect_target),
    .instruction(instruction), .instruction_pc(instruction_pc),
    .instruction_fault(instruction_fault), .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready)
  );

  always #5 clock = ~clock;

  // Reference text memory: words equal their address inside the text segment,
  // 32'h1 outside it.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= TEXT_BEGIN && a <= TEXT_END) return a;
    return 32'h1;
  endfunction

  function automatic logic model_fault(input logic [31:0] pc);
    return ((pc % 4) != 0) || (pc < TEXT_BEGIN) || (pc > TEXT_END);
  endfunction

  // Synchronous-read memory: word for the address seen at an edge appears after it.
  logic [31:0] mem_q = 32'h0;
  always @(posedge clock) mem_q <= mem_word(fetch_address);
  assign data_fetched = mem_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_next   = RESET_PC;
  int          bub        = 0;
  bit          pend_fa    = 1'b0;
  logic [31:0] pend_tgt   = 32'h0;
  bit          prev_stall = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      chk("reset_valid", {31'h0, instruction_valid}, 32'h0);
      chk("reset_instr", instruction, 32'h0);
      chk("reset_pc", instruction_pc, 32'h0);
      chk("reset_fault", {31'h0, instruction_fault}, 32'h0);
      chk("reset_fetch_addr", fetch_address, RESET_PC);
      exp_q.delete();
      exp_next   = RESET_PC;
      bub        = 1;
      pend_fa    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pend_fa) chk("redirect_fetch_addr", fetch_address, pend_tgt);
      pend_fa = 1'b0;
      // Stalled with a valid head: buffer + in-flight is full, address = head + 8.
      if (prev_stall) chk("stall_freeze_addr", fetch_address, instruction_pc + 32'd8);
      if (bub > 0) begin
        chk("bubble_valid_low", {31'h0, instruction_valid}, 32'h0);
        bub--;
      end else begin
        chk("steady_valid_high", {31'h0, instruction_valid}, 32'h1);
      end

      while (exp_q.size() < 4) begin
        exp_q.push_back(exp_next);
        exp_next += 32'd4;
      end
      if (instruction_valid && instruction_ready) begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        pops++;
        chk("pop_pc", instruction_pc, epc);
        chk("pop_instr", instruction, mem_word(epc));
        chk("pop_fault", {31'h0, instruction_fault}, {31'h0, model_fault(epc)});
      end
      prev_stall = instruction_valid && !instruction_ready && !redirect;

      if (redirect) begin
        exp_q.delete();
        exp_next = redirect_target;
        bub      = 2;
        pend_fa  = 1'b1;
        pend_tgt = redirect_target;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rdy, input bit rd, input logic [31:0] tgt);
    @(posedge clock);
    #1;
    instruction_ready = rdy;
    redirect          = rd;
    redirect_target   = tgt;
  endtask

  task automatic pulse_reset(input bit rdy);
    @(posedge clock);
    #1;
    instruction_ready = rdy;
    redirect          = 1'b0;
    #1 reset = 1'b1;
    #5 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0:       return TEXT_BEGIN + 32'({$urandom_range(0, 16383), 2'b00}) + 32'($urandom_range(1, 3));
      1:       return TEXT_END - 32'd4 + 32'({$urandom_range(0, 3), 2'b00});
      2:       return 32'hFFFF_FFF4;
      default: return TEXT_BEGIN + 32'({$urandom_range(0, 16383), 2'b00});
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clock);
    #7 reset = 1'b0;

    // Startup and steady stream.
    repeat (12) cyc(1'b1, 1'b0, 32'h0);
    // Backpressure: 5 stalled cycles then release.
    repeat (5) cyc(1'b0, 1'b0, 32'h0);
    repeat (6) cyc(1'b1, 1'b0, 32'h0);
    // Redirect while the buffer is full.
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0040_0100);
    repeat (8) cyc(1'b1, 1'b0, 32'h0);
    // Misaligned and out-of-range targets, then wrap past 2^32.
    cyc(1'b1, 1'b1, 32'h0040_0102);
    repeat (5) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0041_0000);
    repeat (5) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (6) cyc(1'b1, 1'b0, 32'h0);
    // Ready toggling, redirect coinciding with a pop.
    for (int i = 0; i < 6; i++) cyc(i[0], 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0040_0200);
    for (int i = 0; i < 8; i++) cyc(i[0], 1'b0, 32'h0);
    // Asynchronous reset with the buffer full.
    repeat (4) cyc(1'b0, 1'b0, 32'h0);
    pulse_reset(1'b1);
    repeat (10) cyc(1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset($urandom_range(0, 1) == 1);
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, rand_target());
      end
    end
    cyc(1'b1, 1'b0, 32'h0);
    @(posedge clock);
    @(negedge clock);
    chk("progress_pops_gt_1000", {31'h0, pops > 1000}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
